// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants and types for the MEM-stage data RAM responder.
package data_ram_ctrl_pkg;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int REG_BUS = 32;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
    localparam int DATA_MEM_NUM_LOG2 = 10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef struct packed {
        logic               we;
        logic [3:0]         sel;
        logic [REG_BUS-1:0] data;
    } req_t;

endpackage

// File: rtl/data_ram_ctrl_if.sv
// MEM-stage <-> data RAM request/response bundle.
interface data_ram_ctrl_if;
    import data_ram_ctrl_pkg::*;

    logic               mem_ce_i;
    logic               mem_we_i;
    logic [REG_BUS-1:0] mem_addr_i;
    logic [3:0]         mem_sel_i;
    logic [REG_BUS-1:0] mem_data_i;
    logic [REG_BUS-1:0] mem_data_o;
    logic               stallreq_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, stallreq_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, stallreq_o
    );

endinterface

// File: rtl/data_ram_ctrl_array.sv
// Four byte-wide banks with per-lane write enables and a registered read port.
module data_ram_array
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DATA_MEM_NUM_LOG2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         wr_en,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  idx,
    input  logic [REG_BUS-1:0] wdata,
    output logic [REG_BUS-1:0] rdata
);

    logic [3:0][7:0] rd_byte;

    // Lane b holds data bits [8b+7:8b]; bank 3 is the lowest byte address.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] mem [2**ADDR_W];

        always_ff @(posedge clk) begin
            if (wr_en[b]) begin
                mem[idx] <= wdata[8*b +: 8];
            end
        end

        assign rd_byte[b] = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= ZERO_WORD;
        end else if (rd_en) begin
            rdata <= rd_byte;
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM responder: captures one MEM-stage request, stalls for LATENCY+1 cycles,
// then performs the store or registered load.
//   state | meaning
//   IDLE  | no access in flight; a valid request stalls immediately and is captured
//   WAIT  | latency countdown; access happens at the edge where cnt reaches 0
//   DONE  | load data valid, stall released, pipeline advances
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DATA_MEM_NUM_LOG2,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_ram_ctrl_if.slave bus
);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_idx;
    req_t              cap;
    logic              fire;
    logic [3:0]        wr_en;
    logic              rd_en;
    logic              unused_addr;

    // Byte offset is carried by sel; upper bits alias.
    assign unused_addr = ^{bus.mem_addr_i[REG_BUS-1:ADDR_W+2], bus.mem_addr_i[1:0]};

    assign fire  = !rst && (state == ST_WAIT) && (cnt == 4'd0);
    assign wr_en = (fire && cap.we == WRITE_ENABLE) ? cap.sel : 4'b0000;
    assign rd_en = fire && (cap.we != WRITE_ENABLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            cap_idx <= '0;
            cap     <= '{we: WRITE_DISABLE, sel: 4'b0000, data: ZERO_WORD};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_ce_i == CHIP_ENABLE) begin
                        cap_idx  <= bus.mem_addr_i[ADDR_W+1:2];
                        cap.we   <= bus.mem_we_i;
                        cap.sel  <= bus.mem_sel_i;
                        cap.data <= bus.mem_data_i;
                        cnt      <= 4'(LATENCY - 1);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stallreq_o = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: bus.stallreq_o = (bus.mem_ce_i == CHIP_ENABLE);
                ST_WAIT: bus.stallreq_o = 1'b1;
                default: bus.stallreq_o = 1'b0;
            endcase
        end
    end

    data_ram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .idx   (cap_idx),
        .wdata (cap.data),
        .rdata (bus.mem_data_o)
    );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: two instances (LATENCY=2 and LATENCY=1)
// checked every cycle against a transaction-level memory model.
module tb_data_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        ce   [2];
    logic        we   [2];
    logic [31:0] addr [2];
    logic [3:0]  sel  [2];
    logic [31:0] wd   [2];
    logic        st   [2];
    logic [31:0] dout [2];

    data_ram_ctrl_if bus0();
    data_ram_ctrl_if bus1();

    assign bus0.mem_ce_i   = ce[0];
    assign bus0.mem_we_i   = we[0];
    assign bus0.mem_addr_i = addr[0];
    assign bus0.mem_sel_i  = sel[0];
    assign bus0.mem_data_i = wd[0];
    assign st[0]   = bus0.stallreq_o;
    assign dout[0] = bus0.mem_data_o;

    assign bus1.mem_ce_i   = ce[1];
    assign bus1.mem_we_i   = we[1];
    assign bus1.mem_addr_i = addr[1];
    assign bus1.mem_sel_i  = sel[1];
    assign bus1.mem_data_i = wd[1];
    assign st[1]   = bus1.stallreq_o;
    assign dout[1] = bus1.mem_data_o;

    data_ram_ctrl #(.ADDR_W(10), .LATENCY(2)) u_dut0 (
        .clk (clk), .rst (rst[0]), .bus (bus0.slave)
    );
    data_ram_ctrl #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk (clk), .rst (rst[1]), .bus (bus1.slave)
    );

    int          errors = 0;
    int          checks = 0;
    bit          chk = 1'b0;
    logic        exp_st [2];
    logic [31:0] exp_do [2];
    logic [31:0] mdl [2][1024];

    function automatic int lat(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("stall%0d", d), 32'(st[d]), 32'(exp_st[d]));
                check($sformatf("data%0d", d), dout[d], exp_do[d]);
            end
        end
    end

    // One request as the MEM stage sees it: inputs held while stalled, still
    // present in the release cycle, dropped the cycle after.
    task automatic req(input int d, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] dat, output int ns);
        int          idx;
        logic [31:0] word;
        idx = int'(a[11:2]);
        ns  = 0;
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wd[d] = dat;
        exp_st[d] = 1'b1;
        for (int k = 0; k <= lat(d); k++) begin
            @(negedge clk);
            if (st[d]) ns++;
            @(posedge clk); #1;
        end
        exp_st[d] = 1'b0;
        if (w) begin
            word = mdl[d][idx];
            for (int b = 0; b < 4; b++)
                if (s[b]) word[8*b +: 8] = dat[8*b +: 8];
            mdl[d][idx] = word;
        end else begin
            exp_do[d] = mdl[d][idx];
        end
        @(negedge clk);
        if (st[d]) ns++;
        @(posedge clk); #1;
        ce[d] = 1'b0; we[d] = 1'b0;
    endtask

    initial begin
        int ns;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; ce[d] = 1'b0; we[d] = 1'b0;
            addr[d] = '0; sel[d] = '0; wd[d] = '0;
            exp_st[d] = 1'b0; exp_do[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 chk = 1'b1;
        @(negedge clk);
        check("reset_data0", dout[0], 32'h0);
        check("reset_stall0", 32'(st[0]), 32'h0);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Prior contents at 0x10, loaded so mem_data_o is non-zero before the reset.
        req(0, 1'b1, 32'h10, 4'hF, 32'h0BADF00D, ns);
        req(0, 1'b0, 32'h10, 4'hF, 32'h0, ns);
        check("lw10_pre", dout[0], 32'h0BADF00D);

        // Reset during WAIT of a store drops the store.
        ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; sel[0] = 4'hF; wd[0] = 32'hDEADBEEF;
        exp_st[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b1; exp_st[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", 32'(st[0]), 32'h0);
        @(posedge clk); #1;
        rst[0] = 1'b0; ce[0] = 1'b0; we[0] = 1'b0; exp_do[0] = 32'h0;
        check("rst_mid_data", dout[0], 32'h0);
        req(0, 1'b0, 32'h10, 4'hF, 32'h0, ns);
        check("lw10_post_rst", dout[0], 32'h0BADF00D);

        // Full-word store/load, stall length LATENCY+1.
        req(0, 1'b1, 32'h20, 4'hF, 32'h12345678, ns);
        check("sw20_stalls", 32'(ns), 32'd3);
        check("sw20_hold", dout[0], 32'h0BADF00D);
        req(0, 1'b0, 32'h20, 4'hF, 32'h0, ns);
        check("lw20_stalls", 32'(ns), 32'd3);
        check("lw20_data", dout[0], 32'h12345678);

        // Byte lane, halfword, zero-sel store.
        req(0, 1'b1, 32'h40, 4'hF, 32'h00000000, ns);
        req(0, 1'b1, 32'h41, 4'b0100, 32'hABABABAB, ns);
        req(0, 1'b0, 32'h40, 4'hF, 32'h0, ns);
        check("lw40_byte", dout[0], 32'h00AB0000);
        req(0, 1'b1, 32'h42, 4'b0011, 32'hCAFECAFE, ns);
        req(0, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, ns);
        check("sel0_stalls", 32'(ns), 32'd3);
        req(0, 1'b0, 32'h40, 4'b0001, 32'h0, ns);
        check("lw40_half", dout[0], 32'h00ABCAFE);

        // Back-to-back with aliasing: 0x1000 maps to word 0.
        req(0, 1'b1, 32'h0, 4'hF, 32'h11111111, ns);
        req(0, 1'b0, 32'h1000, 4'hF, 32'h0, ns);
        check("b2b_stalls", 32'(ns), 32'd3);
        check("alias_data", dout[0], 32'h11111111);

        // LATENCY=1 instance: two-cycle stall and hold through idle.
        req(1, 1'b1, 32'h80, 4'hF, 32'h55AA55AA, ns);
        check("l1_sw_stalls", 32'(ns), 32'd2);
        req(1, 1'b0, 32'h80, 4'hF, 32'h0, ns);
        check("l1_lw_stalls", 32'(ns), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("l1_idle_data", dout[1], 32'h55AA55AA);
            check("l1_idle_stall", 32'(st[1]), 32'h0);
        end

        @(posedge clk); #1;
        chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Responder end of the MEM-stage data-memory interface.
- Accepts word/byte-lane load and store requests (ce, we, sel, addr, data) from the MEM stage and services them against an on-chip word array after a configurable access latency.
- Holds the pipeline via a stall request while an access is in flight, and returns load data on mem_data_o.
- Sits between the MEM stage and the pipeline control block, replacing the ideal zero-latency data RAM.

Parameters:
- ADDR_W, 10, log2 of number of 32-bit words stored; word index = mem_addr_i[ADDR_W+1:2].
- LATENCY, 2, clock cycles spent in WAIT before the array access; legal range 1..15.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset (`RstEnable = 1'b1)
- mem_ce_i  input  1  request valid (`ChipEnable)
- mem_we_i  input  1  1 = store, 0 = load
- mem_addr_i  input  32  byte address; bits [1:0] ignored, lanes chosen by sel
- mem_sel_i  input  4  byte-lane enables, big-endian: sel[3]=data[31:24]=byte addr+0 ... sel[0]=data[7:0]=byte addr+3
- mem_data_i  input  32  store data, pre-replicated to lanes by MEM stage
- mem_data_o  output  32  load data, full word; MEM stage extracts lanes
- stallreq_o  output  1  hold pipeline at MEM while 1

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE, cnt=0, mem_data_o=0, captured request regs=0.
  - stallreq_o is 0 while rst=1.
  - Array contents are NOT cleared. An in-flight store is dropped; no partial write occurs.
- FSM states:
  - IDLE:
    - stallreq_o = mem_ce_i (combinational; the same-cycle request must stall).
    - If mem_ce_i: capture addr index, we, sel, data; cnt <= LATENCY-1; go WAIT.
  - WAIT:
    - stallreq_o=1; inputs ignored (pipeline held).
    - If cnt!=0: cnt <= cnt-1.
    - If cnt==0, perform the access at this edge and go DONE:
      - Store: write each lane with sel bit 1; lanes with sel bit 0 are unchanged.
      - Load: mem_data_o <= array[idx].
  - DONE:
    - stallreq_o=0; mem_data_o is valid this cycle, and the pipeline advances at this edge.
    - mem_ce_i is ignored (it is the request just served); go IDLE.
- Timing:
  - Request first seen in cycle T: stall high T..T+LATENCY; data valid in T+LATENCY+1; stall cycles = LATENCY+1.
  - Back-to-back requests: a new request can be seen no earlier than the IDLE cycle after DONE, where it stalls immediately.
- mem_data_o:
  - Updated only by loads.
  - Holds its last load value through stores and idle cycles.
- Store with sel=4'b0000: full handshake runs, but there is no array change.
- Load ignores sel: the whole word is always returned.
- Address bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2^ADDR_W bytes.
- Load directly after store to the same word returns the updated word, because the store has completed before DONE.
- Unknown/X on mem_ce_i outside rst is not specified.

Decomposition:
- Shared defines header gets: `ChipEnable/`ChipDisable, `WriteEnable/`WriteDisable, `RegBus, `ZeroWord, `DataMemNumLog2 (default for ADDR_W), and the FSM state encodings (IDLE=2'b00, WAIT=2'b01, DONE=2'b10).
- One sub-module, data_ram_array:
  - Four 8-bit banks of 2^ADDR_W entries with per-bank write enables.
  - Synchronous write, synchronous read registered into mem_data_o.
  - The controller holds the FSM, counter and captured request.

Test Plan:
- Reset mid-store: SW 0xDEADBEEF to addr 0x10, assert rst during WAIT -> stall drops, mem_data_o=0; a later LW 0x10 returns the prior contents, not 0xDEADBEEF.
- Full word, LATENCY=2: SW 0x12345678 to 0x20, then LW 0x20 (sel 4'b1111) -> stallreq_o high 3 cycles each; mem_data_o=0x12345678 in the cycle after the last stall.
- Byte lanes: SW 0x00000000 to 0x40; SB 0xAB with data 0xABABABAB, sel 4'b0100 at 0x41 -> LW 0x40 returns 0x00AB0000.
- Halfword + zero sel: SH data 0xCAFECAFE sel 4'b0011 at 0x42, then store with sel 4'b0000 and data 0xFFFFFFFF -> LW 0x40 returns 0x00ABCAFE.
- Back-to-back and aliasing, ADDR_W=10: SW 0x11111111 at 0x0, then immediately LW 0x1000 -> no overlap of the two accesses (the second stall starts after DONE); load returns 0x11111111.
- LATENCY=1 and hold: idle 5 cycles with ce=0 after a load of 0x55AA55AA -> stallreq_o=0 and mem_data_o stays 0x55AA55AA; a single load stalls exactly 2 cycles.
